// File: rtl/dmem_bus_bridge.sv
// Data-RAM request to req/ack bus bridge: turns a single-cycle memory-stage access into a
// variable-latency bus transaction, holding the pipeline until it completes, flushes or times out.
module dmem_bus_bridge #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        dce,
    input  logic [3:0]  we,
    input  logic [3:0]  dre,
    input  logic [31:0] daddr,
    input  logic [31:0] din,
    input  logic        flush,
    output logic        stall_req,
    output logic [31:0] dm_rdata,
    output logic        dm_rvalid,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, DONE, ABORT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              bus_req_reg, bus_req_next;
    logic              bus_wr_reg, bus_wr_next;
    logic [3:0]        bus_be_reg, bus_be_next;
    logic [31:0]       bus_addr_reg, bus_addr_next;
    logic [31:0]       bus_wdata_reg, bus_wdata_next;
    logic [31:0]       dm_rdata_reg, dm_rdata_next;
    logic              dm_rvalid_reg, dm_rvalid_next;
    logic              bus_err_reg, bus_err_next;

    logic              is_write;
    logic [3:0]        be_sel;
    logic              timeout;

    assign is_write = |we;
    assign timeout  = (cnt_reg == CNT_LAST);

    // Stores drive the store lanes, loads the load lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_be_lane
            assign be_sel[gi] = is_write ? we[gi] : dre[gi];
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        bus_req_next   = bus_req_reg;
        bus_wr_next    = bus_wr_reg;
        bus_be_next    = bus_be_reg;
        bus_addr_next  = bus_addr_reg;
        bus_wdata_next = bus_wdata_reg;
        dm_rdata_next  = dm_rdata_reg;
        dm_rvalid_next = 1'b0;
        bus_err_next   = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (dce && !flush) begin
                    bus_wr_next    = is_write;
                    bus_be_next    = be_sel;
                    bus_addr_next  = daddr & 32'hFFFF_FFFC;
                    bus_wdata_next = din;
                    bus_req_next   = 1'b1;
                    state_next     = REQ;
                end
            end
            REQ: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (bus_ack) begin
                    bus_req_next = 1'b0;
                    cnt_next     = '0;
                    if (flush) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DONE;
                        if (!bus_wr_reg) begin
                            dm_rdata_next  = bus_rdata;
                            dm_rvalid_next = 1'b1;
                        end
                    end
                end else if (timeout) begin
                    bus_req_next = 1'b0;
                    bus_err_next = 1'b1;
                    cnt_next     = '0;
                    if (flush) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DONE;
                        if (!bus_wr_reg) begin
                            dm_rdata_next = '0;
                        end
                    end
                end else if (flush) begin
                    // The slave already saw the request; wait it out in ABORT.
                    state_next = ABORT;
                end
            end
            DONE: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            ABORT: begin
                cnt_next = cnt_reg + CNT_W'(1);
                if (bus_ack) begin
                    bus_req_next = 1'b0;
                    cnt_next     = '0;
                    state_next   = IDLE;
                end else if (timeout) begin
                    bus_req_next = 1'b0;
                    bus_err_next = 1'b1;
                    cnt_next     = '0;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (!cpu_rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bus_req_reg   <= 1'b0;
            bus_wr_reg    <= 1'b0;
            bus_be_reg    <= '0;
            bus_addr_reg  <= '0;
            bus_wdata_reg <= '0;
            dm_rdata_reg  <= '0;
            dm_rvalid_reg <= 1'b0;
            bus_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bus_req_reg   <= bus_req_next;
            bus_wr_reg    <= bus_wr_next;
            bus_be_reg    <= bus_be_next;
            bus_addr_reg  <= bus_addr_next;
            bus_wdata_reg <= bus_wdata_next;
            dm_rdata_reg  <= dm_rdata_next;
            dm_rvalid_reg <= dm_rvalid_next;
            bus_err_reg   <= bus_err_next;
        end
    end

    // DONE never stalls so the pipeline moves past the finished access.
    assign stall_req = cpu_rst_n & (((state_reg == IDLE) & dce & ~flush)
                                    | (state_reg == REQ)
                                    | ((state_reg == ABORT) & dce));

    assign bus_req   = bus_req_reg;
    assign bus_wr    = bus_wr_reg;
    assign bus_be    = bus_be_reg;
    assign bus_addr  = bus_addr_reg;
    assign bus_wdata = bus_wdata_reg;
    assign dm_rdata  = dm_rdata_reg;
    assign dm_rvalid = dm_rvalid_reg;
    assign bus_err   = bus_err_reg;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: directed accesses push expected bus transactions, stall/request
// run lengths, read data and timeout events; a negedge monitor pops and compares as the DUT produces them.
module tb_dmem_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dce;
    logic [3:0]  we;
    logic [3:0]  dre;
    logic [31:0] daddr;
    logic [31:0] din;
    logic        flush;
    logic        stall_req;
    logic [31:0] dm_rdata;
    logic        dm_rvalid;
    logic        bus_err;
    logic        bus_req;
    logic        bus_wr;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    bus_t        exp_bus[$];
    int          exp_stall[$];
    int          exp_req[$];
    logic [31:0] exp_rd[$];
    logic [31:0] exp_err[$];

    dmem_bus_bridge #(.TIMEOUT_CYC(4), .CNT_W(3)) dut (
        .cpu_clk_50M (clk),
        .cpu_rst_n   (rst_n),
        .dce         (dce),
        .we          (we),
        .dre         (dre),
        .daddr       (daddr),
        .din         (din),
        .flush       (flush),
        .stall_req   (stall_req),
        .dm_rdata    (dm_rdata),
        .dm_rvalid   (dm_rvalid),
        .bus_err     (bus_err),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_be      (bus_be),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_bus(input logic wr, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input int req_len, input int stall_len);
        bus_t b;
        b.wr = wr; b.be = be; b.addr = addr; b.wdata = wdata;
        exp_bus.push_back(b);
        exp_req.push_back(req_len);
        exp_stall.push_back(stall_len);
    endtask

    // Cycle 0 presents the access; cycles 1..n follow with ack/flush at the given cycle indices.
    task automatic access(input logic [3:0] we_v, input logic [3:0] dre_v, input logic [31:0] addr_v,
                          input logic [31:0] din_v, input logic [31:0] rdata_v,
                          input int ack_at, input int flush_at, input int dce_until, input int n);
        dce = 1'b1; we = we_v; dre = dre_v; daddr = addr_v; din = din_v;
        bus_rdata = rdata_v; flush = 1'b0; bus_ack = 1'b0;
        for (int k = 1; k <= n; k++) begin
            step();
            dce     = (k <= dce_until);
            flush   = (k == flush_at);
            bus_ack = (k == ack_at);
        end
        step();
        dce = 1'b0; flush = 1'b0; bus_ack = 1'b0;
        $display("access addr=%h we=%h dre=%h ack_at=%0d flush_at=%0d done", addr_v, we_v, dre_v, ack_at, flush_at);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_bus_req"},   {31'd0, bus_req},   32'd0);
        chk({tag, "_bus_wr"},    {31'd0, bus_wr},    32'd0);
        chk({tag, "_bus_be"},    {28'd0, bus_be},    32'd0);
        chk({tag, "_bus_addr"},  bus_addr,           32'd0);
        chk({tag, "_bus_wdata"}, bus_wdata,          32'd0);
        chk({tag, "_dm_rdata"},  dm_rdata,           32'd0);
        chk({tag, "_dm_rvalid"}, {31'd0, dm_rvalid}, 32'd0);
        chk({tag, "_bus_err"},   {31'd0, bus_err},   32'd0);
        chk({tag, "_stall_req"}, {31'd0, stall_req}, 32'd0);
    endtask

    // Monitor
    int          stall_run = 0;
    int          req_run = 0;
    logic        req_active = 1'b0;
    bus_t        cur;
    logic [31:0] rdata_model = 32'd0;

    task automatic close_stall();
        if (stall_run > 0) begin
            if (exp_stall.size() == 0) chk("stall_unexpected_run", stall_run, 0);
            else chk("stall_cycles", stall_run, exp_stall.pop_front());
        end
        stall_run = 0;
    endtask

    task automatic close_req();
        if (req_run > 0) begin
            if (exp_req.size() == 0) chk("bus_req_unexpected_run", req_run, 0);
            else chk("bus_req_cycles", req_run, exp_req.pop_front());
        end
        req_run = 0;
        req_active = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("stall_in_reset", {31'd0, stall_req}, 32'd0);
            close_stall();
            close_req();
            rdata_model = 32'd0;
        end else begin
            if (stall_req === 1'b1) stall_run++;
            else close_stall();

            if (bus_req === 1'b1) begin
                if (!req_active) begin
                    if (exp_bus.size() == 0) begin
                        chk("bus_req_unexpected", {31'd0, bus_req}, 32'd0);
                        cur.wr = bus_wr; cur.be = bus_be; cur.addr = bus_addr; cur.wdata = bus_wdata;
                    end else begin
                        cur = exp_bus.pop_front();
                        chk("bus_wr",    {31'd0, bus_wr}, {31'd0, cur.wr});
                        chk("bus_be",    {28'd0, bus_be}, {28'd0, cur.be});
                        chk("bus_addr",  bus_addr,  cur.addr);
                        chk("bus_wdata", bus_wdata, cur.wdata);
                        $display("bus txn wr=%0b be=%h addr=%h wdata=%h", bus_wr, bus_be, bus_addr, bus_wdata);
                    end
                    req_active = 1'b1;
                end else begin
                    chk("bus_stable", {bus_wr, bus_be, bus_addr[26:0]}, {cur.wr, cur.be, cur.addr[26:0]});
                    chk("bus_wdata_stable", bus_wdata, cur.wdata);
                end
                req_run++;
            end else begin
                close_req();
            end

            if (bus_err === 1'b1) begin
                if (exp_err.size() == 0) chk("bus_err_unexpected", {31'd0, bus_err}, 32'd0);
                else rdata_model = exp_err.pop_front();
                $display("bus_err pulse dm_rdata=%h", dm_rdata);
            end
            if (dm_rvalid === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    chk("dm_rvalid_unexpected", {31'd0, dm_rvalid}, 32'd0);
                    rdata_model = dm_rdata;
                end else begin
                    rdata_model = exp_rd.pop_front();
                end
                $display("read return dm_rdata=%h", dm_rdata);
            end
            chk("dm_rdata", dm_rdata, rdata_model);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; dce = 1'b0; we = 4'h0; dre = 4'h0; daddr = 32'h0; din = 32'h0;
        flush = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
        step();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        chk_cleared("reset");
        step();

        // dce together with flush in IDLE must not be accepted
        dce = 1'b1; flush = 1'b1; dre = 4'hF; daddr = 32'h0000_0010;
        step();
        dce = 1'b0; flush = 1'b0;
        step();

        // Read, ack in the third REQ cycle
        expect_bus(1'b0, 4'hF, 32'h1000_0004, 32'h0, 3, 4);
        exp_rd.push_back(32'hCAFE_F00D);
        access(4'h0, 4'hF, 32'h1000_0004, 32'h0, 32'hCAFE_F00D, 3, 0, 4, 5);

        // SB write, ack in the first REQ cycle; byte offset dropped from the address
        expect_bus(1'b1, 4'b0100, 32'h0000_0008, 32'h5A5A_5A5A, 1, 2);
        access(4'b0100, 4'h0, 32'h0000_000A, 32'h5A5A_5A5A, 32'h0BAD_0BAD, 1, 0, 2, 3);

        // Flush in first REQ cycle, ack on the fourth bus cycle (the timeout cycle: ack wins)
        expect_bus(1'b0, 4'b0011, 32'h0000_0020, 32'h0, 4, 2);
        access(4'h0, 4'b0011, 32'h0000_0020, 32'h0, 32'h7777_7777, 4, 1, 1, 6);

        // Timeout with no ack: bus_err once, dm_rdata cleared
        expect_bus(1'b0, 4'hF, 32'h0000_0040, 32'h0, 4, 5);
        exp_err.push_back(32'h0);
        access(4'h0, 4'hF, 32'h0000_0040, 32'h0, 32'h0, 0, 0, 5, 6);

        // Ack together with flush: data discarded
        expect_bus(1'b0, 4'hF, 32'h0000_0044, 32'h0, 1, 2);
        access(4'h0, 4'hF, 32'h0000_0044, 32'h0, 32'hDEAD_BEEF, 1, 1, 1, 3);

        // Ack in the timeout cycle of REQ: ack wins, no bus_err
        expect_bus(1'b0, 4'b1100, 32'h0000_0048, 32'h0, 4, 5);
        exp_rd.push_back(32'h1234_5678);
        access(4'h0, 4'b1100, 32'h0000_0048, 32'h0, 32'h1234_5678, 4, 0, 5, 6);

        // Back-to-back loads, dce high through DONE and into the next access
        expect_bus(1'b0, 4'hF, 32'h0000_0100, 32'h0, 1, 2);
        expect_bus(1'b0, 4'hF, 32'h0000_0104, 32'h0, 1, 2);
        exp_rd.push_back(32'h1111_2222);
        exp_rd.push_back(32'h3333_4444);
        access(4'h0, 4'hF, 32'h0000_0100, 32'h0, 32'h1111_2222, 1, 0, 2, 2);
        access(4'h0, 4'hF, 32'h0000_0104, 32'h0, 32'h3333_4444, 1, 0, 2, 3);

        // Reset asserted during the second REQ cycle
        expect_bus(1'b0, 4'hF, 32'h0000_0200, 32'h0, 1, 2);
        dce = 1'b1; we = 4'h0; dre = 4'hF; daddr = 32'h0000_0200; din = 32'h0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; dce = 1'b0;
        @(negedge clk);
        chk_cleared("midreq_reset");
        $display("reset mid-REQ done");
        step();

        // Fresh write after reset proves the bridge is back in IDLE
        expect_bus(1'b1, 4'hF, 32'h0000_0300, 32'hA5A5_0000, 2, 3);
        access(4'hF, 4'h0, 32'h0000_0300, 32'hA5A5_0000, 32'h0, 2, 0, 3, 4);

        repeat (4) step();
        chk("pending_bus_txns",   exp_bus.size(),   0);
        chk("pending_req_runs",   exp_req.size(),   0);
        chk("pending_stall_runs", exp_stall.size(), 0);
        chk("pending_reads",      exp_rd.size(),    0);
        chk("pending_errs",       exp_err.size(),   0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
